// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/shift/compare ops plus iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both the operation and the result.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b0101, OP_MULHU = 4'b1011, OP_DIVU = 4'b1100, OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d, mul_next, div_next;
    logic [WIDTH-1:0]   b_q, b_d, data_q, data_d, alu_r;
    logic [3:0]         op_q, op_d;
    logic               zero_q, zero_d, zp_q, zp_d;
    logic               accept, is_mc, is_div, last, dge;
    logic [WIDTH:0]     msum, dtry, ddiff;
    logic [SHW-1:0]     sh;

    assign accept = valid_i && (state_q == IDLE);
    assign is_mc  = ALUCtrl_i inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    assign is_div = op_q inside {OP_DIVU, OP_REMU};
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign sh     = data2_i[SHW-1:0];

    // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    assign msum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {msum, p_q[WIDTH-1:1]};
    assign dtry     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign ddiff    = dtry - {1'b0, b_q};
    assign dge      = dtry >= {1'b0, b_q};
    assign div_next = {dge ? ddiff[WIDTH-1:0] : dtry[WIDTH-1:0], p_q[WIDTH-2:0], dge};

    always_comb begin
        case (ALUCtrl_i)
            4'b0000: alu_r = data1_i & data2_i;
            4'b0001: alu_r = data1_i ^ data2_i;
            4'b0010: alu_r = data1_i << sh;
            4'b0011: alu_r = data1_i + data2_i;
            4'b0100: alu_r = data1_i - data2_i;
            4'b0110: alu_r = data1_i | data2_i;
            4'b0111: alu_r = $signed(data1_i) >>> sh;
            4'b1000: alu_r = data1_i >> sh;
            4'b1001: alu_r = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
            4'b1010: alu_r = {{(WIDTH-1){1'b0}}, data1_i < data2_i};
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (is_mc ? BUSY : DONE) : IDLE;
            BUSY:    state_d = last ? DONE : BUSY;
            DONE:    state_d = ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = state_q == IDLE;
    assign valid_o = state_q == DONE;
    assign data_o  = data_q;
    assign Zero_o  = zero_q;

    always_comb begin
        op_d   = op_q;
        b_d    = b_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        zp_d   = zp_q;
        data_d = data_q;
        zero_d = zero_q;
        if (accept) begin
            op_d  = ALUCtrl_i;
            b_d   = data2_i;
            p_d   = {{WIDTH{1'b0}}, data1_i};
            cnt_d = '0;
            zp_d  = data1_i == data2_i;
            if (!is_mc) begin
                data_d = alu_r;
                zero_d = data1_i == data2_i;
            end
        end else if (state_q == BUSY) begin
            p_d   = is_div ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                data_d = (op_q == OP_MUL || op_q == OP_DIVU) ? p_d[WIDTH-1:0] : p_d[2*WIDTH-1:WIDTH];
                zero_d = zp_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q   <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            zp_q   <= 1'b0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            b_q    <= b_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            zp_q   <= zp_d;
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors for a 32-bit and an 8-bit instance with hand-computed results.
module tb_multicycle_alu;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_vi = 0, a_ro, a_vo, a_ri = 0, a_z;
    logic [31:0] a_d1 = 0, a_d2 = 0, a_do;
    logic [3:0]  a_op = 0;
    logic        b_vi = 0, b_ro, b_vo, b_ri = 0, b_z;
    logic [7:0]  b_d1 = 0, b_d2 = 0, b_do;
    logic [3:0]  b_op = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(a_vi), .ready_o(a_ro), .data1_i(a_d1), .data2_i(a_d2),
        .ALUCtrl_i(a_op), .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .Zero_o(a_z)
    );
    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(b_vi), .ready_o(b_ro), .data1_i(b_d1), .data2_i(b_d2),
        .ALUCtrl_i(b_op), .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .Zero_o(b_z)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w8) begin b_vi = 1; b_op = op; b_d1 = a[7:0]; b_d2 = b[7:0]; end
        else    begin a_vi = 1; a_op = op; a_d1 = a;      a_d2 = b;      end
        @(posedge clk);
        #1;
        a_vi = 0; b_vi = 0;
        a_op = 4'h3; a_d1 = ~a; a_d2 = 32'h1234_5678;
        b_op = 4'h3; b_d1 = ~a[7:0]; b_d2 = 8'h5A;
    endtask

    task automatic run(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat, output bit busy_bad);
        start(w8, op, a, b);
        lat = 1;
        busy_bad = 0;
        while (!(w8 ? b_vo : a_vo) && lat < 100) begin
            if (w8 ? b_ro : a_ro) busy_bad = 1;
            @(posedge clk);
            #1;
            lat++;
        end
        r = w8 ? {24'h0, b_do} : a_do;
        z = w8 ? b_z : a_z;
    endtask

    task automatic release_res(input bit w8);
        @(negedge clk);
        if (w8) b_ri = 1; else a_ri = 1;
        @(posedge clk);
        #1;
        a_ri = 0; b_ri = 0;
        chk("ret_ready", w8 ? b_ro : a_ro, 1);
        chk("ret_valid", w8 ? b_vo : a_vo, 0);
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic        z;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [22] = '{
        '{4'h3, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 8'd1},
        '{4'h5, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 8'd33},
        '{4'hB, 32'h00010000, 32'h00010000, 32'h1,        1'b1, 8'd33},
        '{4'hC, 32'd100,      32'd7,        32'd14,       1'b0, 8'd33},
        '{4'hD, 32'd100,      32'd7,        32'd2,        1'b0, 8'd33},
        '{4'hC, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 8'd33},
        '{4'hD, 32'd5,        32'd0,        32'd5,        1'b0, 8'd33},
        '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 8'd1},
        '{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 8'd1},
        '{4'h2, 32'h1,        32'h3F,       32'h80000000, 1'b0, 8'd1},
        '{4'h4, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 8'd1},
        '{4'h6, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 8'd1},
        '{4'h8, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 8'd1},
        '{4'h7, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 8'd1},
        '{4'h9, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 8'd1},
        '{4'hA, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 8'd1},
        '{4'h5, 32'd7,        32'd6,        32'd42,       1'b0, 8'd33},
        '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 8'd33},
        '{4'hE, 32'd5,        32'd5,        32'd0,        1'b1, 8'd1},
        '{4'hF, 32'd9,        32'd5,        32'd0,        1'b0, 8'd1},
        '{4'hC, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0, 8'd33},
        '{4'hD, 32'hFFFFFFFF, 32'h10,       32'hF,        1'b0, 8'd33}
    };

    logic [31:0] r;
    logic        z;
    int          lat;
    bit          bb;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", a_ro, 1);
        chk("rst_valid", a_vo, 0);
        chk("rst_data", a_do, 0);
        chk("rst_zero", a_z, 0);
        chk("rst8_ready", b_ro, 1);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) begin
            run(0, vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, bb);
            chk($sformatf("v%0d_data", i), r, vecs[i].r);
            chk($sformatf("v%0d_zero", i), z, vecs[i].z);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), bb, 0);
            release_res(0);
        end

        // result must hold while the consumer stalls, and a new request must be ignored
        run(0, 4'h7, 32'h80000000, 32'd4, r, z, lat, bb);
        chk("sra_data", r, 32'hF8000000);
        chk("sra_lat", lat, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_vi = (i == 4); a_op = 4'h3; a_d1 = 32'd1; a_d2 = 32'd1;
            chk("hold_data", a_do, 32'hF8000000);
            chk("hold_valid", a_vo, 1);
        end
        @(negedge clk);
        a_vi = 0;
        release_res(0);
        chk("idle_data", a_do, 32'hF8000000);
        chk("idle_zero", a_z, 0);
        @(posedge clk);
        #1;
        chk("no_accept", a_ro, 1);

        // reset in the middle of a divide abandons it immediately
        start(0, 4'hC, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("arst_valid", a_vo, 0);
        chk("arst_ready", a_ro, 1);
        chk("arst_data", a_do, 0);
        #3;
        rst_n = 1;
        run(0, 4'h4, 32'd7, 32'd7, r, z, lat, bb);
        chk("sub_data", r, 0);
        chk("sub_zero", z, 1);
        chk("sub_lat", lat, 1);
        release_res(0);

        run(1, 4'h9, 32'h80, 32'h01, r, z, lat, bb);
        chk("w8_slt", r, 1);
        release_res(1);
        run(1, 4'hA, 32'h80, 32'h01, r, z, lat, bb);
        chk("w8_sltu", r, 0);
        release_res(1);
        run(1, 4'h5, 32'h10, 32'h10, r, z, lat, bb);
        chk("w8_mul", r, 0);
        chk("w8_mul_lat", lat, 9);
        chk("w8_mul_zero", z, 1);
        chk("w8_mul_busy", bb, 0);
        release_res(1);
        run(1, 4'hC, 32'hC8, 32'h03, r, z, lat, bb);
        chk("w8_divu", r, 32'h42);
        chk("w8_divu_lat", lat, 9);
        release_res(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
